// File: rtl/bt_channel.sv
// Channel side of a System/360 bus-and-tag interface.
// Runs one command to one control unit: initial selection, command out,
// initial status, byte transfer loop with stop, ending status and disconnect.
module bt_channel #(
   parameter int SELECT_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] a_bus_in,
   output logic [7:0] a_bus_out,
   output logic       a_operational_out,
   input  logic       a_request_in,
   output logic       a_hold_out,
   output logic       a_select_out,
   input  logic       a_select_in,
   output logic       a_address_out,
   input  logic       a_operational_in,
   input  logic       a_address_in,
   output logic       a_command_out,
   input  logic       a_status_in,
   input  logic       a_service_in,
   output logic       a_service_out,
   output logic       a_suppress_out,
   input  logic [7:0] address,
   input  logic [7:0] command,
   input  logic [7:0] count,
   input  logic       start_strobe
);

   typedef enum logic [3:0] {
      STATE_IDLE        = 4'd0,
      STATE_SELECT      = 4'd1,
      STATE_COMMAND     = 4'd2,
      STATE_INIT_STATUS = 4'd3,
      STATE_INIT_ACK    = 4'd4,
      STATE_DATA        = 4'd5,
      STATE_DATA_ACK    = 4'd6,
      STATE_END_ACK     = 4'd7,
      STATE_DISCONNECT  = 4'd8
   } state_e;

   localparam int              CNT_W     = $clog2(SELECT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] SEL_LAST = CNT_W'(SELECT_TIMEOUT - 1);
   localparam logic [7:0]      CMD_WRITE = 8'h01;
   localparam logic [7:0]      CMD_READ  = 8'h02;
   // Busy, channel end and unit check in initial status end the operation.
   localparam logic [7:0]      END_MASK  = 8'h1A;

   state_e           state, state_d;
   logic [7:0]       res_count, res_count_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [7:0]       count_q, count_d;
   logic [7:0]       status_q, status_d;
   logic [7:0]       rd_byte_q, rd_byte_d;
   logic             xfer_q, xfer_d;
   logic [CNT_W-1:0] sel_cnt_q, sel_cnt_d;

   // CU-initiated sequences are not supported, so request-in is never looked at.
   logic unused_request;
   assign unused_request = a_request_in;

   assign a_operational_out = ~reset;
   assign a_hold_out        = a_select_out;
   assign a_suppress_out    = 1'b0;

   // State and datapath registers; synchronous reset drops every tag at once.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state     <= STATE_IDLE;
         res_count <= '0;
         addr_q    <= '0;
         cmd_q     <= '0;
         count_q   <= '0;
         status_q  <= '0;
         rd_byte_q <= '0;
         xfer_q    <= 1'b0;
         sel_cnt_q <= '0;
      end else begin
         state     <= state_d;
         res_count <= res_count_d;
         addr_q    <= addr_d;
         cmd_q     <= cmd_d;
         count_q   <= count_d;
         status_q  <= status_d;
         rd_byte_q <= rd_byte_d;
         xfer_q    <= xfer_d;
         sel_cnt_q <= sel_cnt_d;
      end
   end

   // Next-state logic and tag outputs decoded from the current state.
   always_comb begin
      // NOTE: every variable gets a default here so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d       = state;
      res_count_d   = res_count;
      addr_d        = addr_q;
      cmd_d         = cmd_q;
      count_d       = count_q;
      status_d      = status_q;
      rd_byte_d     = rd_byte_q;
      xfer_d        = xfer_q;
      sel_cnt_d     = sel_cnt_q;
      a_bus_out     = '0;
      a_select_out  = 1'b0;
      a_address_out = 1'b0;
      a_command_out = 1'b0;
      a_service_out = 1'b0;

      case (state)
         STATE_IDLE: begin
            if (start_strobe) begin
               addr_d      = address;
               cmd_d       = command;
               count_d     = count;
               res_count_d = count;
               sel_cnt_d   = '0;
               state_d     = STATE_SELECT;
            end
         end

         STATE_SELECT: begin
            a_select_out  = 1'b1;
            a_address_out = 1'b1;
            a_bus_out     = addr_q;
            if (a_select_in || (sel_cnt_q == SEL_LAST)) begin
               state_d = STATE_IDLE;
            end else if (a_operational_in && a_address_in) begin
               state_d = STATE_COMMAND;
            end else begin
               sel_cnt_d = sel_cnt_q + 1'b1;
            end
         end

         STATE_COMMAND: begin
            a_select_out  = 1'b1;
            a_command_out = 1'b1;
            a_bus_out     = cmd_q;
            if (!a_address_in) state_d = STATE_INIT_STATUS;
         end

         STATE_INIT_STATUS: begin
            a_select_out = 1'b1;
            if (a_status_in) begin
               status_d = a_bus_in;
               state_d  = STATE_INIT_ACK;
            end
         end

         STATE_INIT_ACK: begin
            a_select_out  = 1'b1;
            a_service_out = 1'b1;
            if (!a_status_in) begin
               state_d = ((status_q & END_MASK) != 8'h00) ? STATE_DISCONNECT : STATE_DATA;
            end
         end

         STATE_DATA: begin
            a_select_out = 1'b1;
            if (a_service_in) begin
               // With nothing left to move, the byte request is answered by stop.
               xfer_d = (res_count != 8'd0);
               if ((res_count != 8'd0) && (cmd_q == CMD_READ)) rd_byte_d = a_bus_in;
               state_d = STATE_DATA_ACK;
            end else if (a_status_in) begin
               status_d = a_bus_in;
               state_d  = STATE_END_ACK;
            end
         end

         STATE_DATA_ACK: begin
            a_select_out = 1'b1;
            if (xfer_q) begin
               a_service_out = 1'b1;
               // Write data is the byte index within the transfer.
               if (cmd_q == CMD_WRITE) a_bus_out = count_q - res_count;
            end else begin
               a_command_out = 1'b1;
            end
            if (!a_service_in) begin
               if (xfer_q && (res_count != 8'd0)) res_count_d = res_count - 8'd1;
               state_d = STATE_DATA;
            end
         end

         STATE_END_ACK: begin
            a_select_out  = 1'b1;
            a_service_out = 1'b1;
            if (!a_status_in) state_d = STATE_DISCONNECT;
         end

         STATE_DISCONNECT: begin
            a_select_out = 1'b1;
            if (!a_operational_in) state_d = STATE_IDLE;
         end

         default: state_d = STATE_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bt_channel.sv
// Testbench for bt_channel: a behavioural control-unit peer on a select loop
// with terminator, a directed vector table, randomized transfers checked
// against a transfer-count model, and reset / ignored-strobe corner cases.
module tb_bt_channel;

   localparam logic [3:0] IDLE_CODE = 4'd0;
   localparam logic [7:0] CU_ADDR   = 8'h20;
   localparam logic [7:0] BUSY_ADDR = 8'h1a;

   logic       clk;
   logic       reset;
   logic [7:0] a_bus_in, a_bus_out;
   logic       a_operational_out, a_request_in, a_hold_out, a_select_out;
   logic       a_select_in, a_address_out, a_operational_in, a_address_in;
   logic       a_command_out, a_status_in, a_service_in, a_service_out, a_suppress_out;
   logic [7:0] address, command, count;
   logic       start_strobe;

   bt_channel #(.SELECT_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .a_bus_in(a_bus_in), .a_bus_out(a_bus_out),
      .a_operational_out(a_operational_out), .a_request_in(a_request_in),
      .a_hold_out(a_hold_out), .a_select_out(a_select_out), .a_select_in(a_select_in),
      .a_address_out(a_address_out), .a_operational_in(a_operational_in),
      .a_address_in(a_address_in), .a_command_out(a_command_out),
      .a_status_in(a_status_in), .a_service_in(a_service_in),
      .a_service_out(a_service_out), .a_suppress_out(a_suppress_out),
      .address(address), .command(command), .count(count), .start_strobe(start_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- mock control unit ----------------
   logic [7:0] rd_data [64];
   logic [7:0] wr_q [$];
   int         cu_offer;
   bit         cu_term;

   function automatic logic cu_sig(input int s);
      case (s)
         0:       return a_command_out;
         1:       return a_service_out;
         2:       return a_service_out | a_command_out;
         default: return a_select_out;
      endcase
   endfunction

   // Waits for a channel tag to reach a level; gives up on timeout or deselection.
   task automatic cu_wait(input int s, input logic v, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cu_sig(s) === v) begin
            ok = 1'b1;
            return;
         end
         if (a_select_out !== 1'b1) return;
      end
   endtask

   task automatic cu_drop();
      bit ok;
      a_operational_in = 1'b0; a_address_in = 1'b0; a_status_in = 1'b0;
      a_service_in = 1'b0; a_select_in = 1'b0; a_bus_in = 8'h00;
      cu_wait(3, 1'b0, ok);
   endtask

   task automatic cu_status(input logic [7:0] st, output bit ok);
      a_bus_in = st; a_status_in = 1'b1;
      cu_wait(1, 1'b1, ok);
      if (!ok) return;
      a_status_in = 1'b0; a_bus_in = 8'h00;
      cu_wait(1, 1'b0, ok);
   endtask

   task automatic cu_session();
      bit ok, stopped;
      int i;
      logic [7:0] sel_addr, cmd, st;
      sel_addr = a_bus_out;
      if (sel_addr != CU_ADDR && sel_addr != BUSY_ADDR) begin
         if (cu_term) begin
            @(negedge clk);
            @(negedge clk);
            a_select_in = 1'b1;
         end
         cu_wait(3, 1'b0, ok);
         a_select_in = 1'b0;
         return;
      end
      a_operational_in = 1'b1; a_address_in = 1'b1; a_bus_in = sel_addr;
      cu_wait(0, 1'b1, ok);
      if (!ok) begin cu_drop(); return; end
      cmd = a_bus_out;
      a_address_in = 1'b0; a_bus_in = 8'h00;
      cu_wait(0, 1'b0, ok);
      if (!ok) begin cu_drop(); return; end
      if (sel_addr == BUSY_ADDR)             st = 8'h10;
      else if (cmd == 8'h01 || cmd == 8'h02) st = 8'h00;
      else if (cmd == 8'h03)                 st = 8'h0C;
      else                                   st = 8'h02;
      cu_status(st, ok);
      if (!ok) begin cu_drop(); return; end
      if (st == 8'h00) begin
         i = 0;
         stopped = 1'b0;
         while (!stopped && i < cu_offer) begin
            a_bus_in = rd_data[i]; a_service_in = 1'b1;
            cu_wait(2, 1'b1, ok);
            if (!ok) begin cu_drop(); return; end
            if (a_command_out) begin
               stopped = 1'b1;
               a_service_in = 1'b0; a_bus_in = 8'h00;
               cu_wait(0, 1'b0, ok);
            end else begin
               if (cmd == 8'h01) wr_q.push_back(a_bus_out);
               a_service_in = 1'b0; a_bus_in = 8'h00;
               cu_wait(1, 1'b0, ok);
               i++;
            end
            if (!ok) begin cu_drop(); return; end
         end
         cu_status(8'h0C, ok);
         if (!ok) begin cu_drop(); return; end
      end
      cu_drop();
   endtask

   initial begin
      a_bus_in = 8'h00; a_request_in = 1'b0; a_select_in = 1'b0; a_operational_in = 1'b0;
      a_address_in = 1'b0; a_status_in = 1'b0; a_service_in = 1'b0;
      forever begin
         @(negedge clk);
         if (a_select_out === 1'b1) cu_session();
      end
   end

   // ---------------- reference model ----------------
   // Bytes moved = what both sides agree on: data commands at the live CU only.
   function automatic int model_xfer(input logic [7:0] addr, input logic [7:0] cmd,
                                     input int cnt, input int offer);
      if (addr != CU_ADDR || !(cmd == 8'h01 || cmd == 8'h02)) return 0;
      return (offer < cnt) ? offer : cnt;
   endfunction

   // ---------------- operation runner ----------------
   task automatic run_op(input int id, input logic [7:0] addr, input logic [7:0] cmd,
                         input logic [7:0] cnt, input int offer, input bit term, input bit mid,
                         input logic [7:0] exp_res, input int exp_n, input int min_c, input int max_c);
      int cyc;
      bit hold_bad;
      for (int k = 0; k < 64; k++) rd_data[k] = 8'($urandom);
      wr_q.delete();
      cu_offer = offer;
      cu_term  = term;
      address = addr; command = cmd; count = cnt; start_strobe = 1'b1;
      @(negedge clk);
      start_strobe = 1'b0;
      cyc = 1;
      hold_bad = 1'b0;
      while (dut.state != IDLE_CODE && cyc < 300) begin
         if (mid && cyc == 10) begin
            count = 8'd3; command = 8'h01; start_strobe = 1'b1;
         end else begin
            start_strobe = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (a_hold_out !== a_select_out || a_suppress_out !== 1'b0) hold_bad = 1'b1;
      end
      start_strobe = 1'b0;
      check($sformatf("op%0d idle_within_bound", id), 32'(cyc <= max_c), 32'd1);
      check($sformatf("op%0d min_latency", id), 32'(cyc >= min_c), 32'd1);
      check($sformatf("op%0d res_count", id), 32'(dut.res_count), 32'(exp_res));
      check($sformatf("op%0d write_bytes", id), 32'(wr_q.size()), (cmd == 8'h01) ? 32'(exp_n) : 32'd0);
      for (int i = 0; i < wr_q.size(); i++)
         check($sformatf("op%0d write_byte%0d", id, i), 32'(wr_q[i]), 32'(i));
      if (cmd == 8'h02 && exp_n > 0)
         check($sformatf("op%0d read_capture", id), 32'(dut.rd_byte_q), 32'(rd_data[exp_n-1]));
      check($sformatf("op%0d tags_idle", id),
            32'({a_select_out, a_hold_out, a_address_out, a_command_out, a_service_out, a_bus_out}), 32'd0);
      check($sformatf("op%0d hold_eq_select", id), 32'(hold_bad), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] cmd;
      logic [7:0] cnt;
      int         offer;
      bit         term;
      bit         mid;
      logic [7:0] exp_res;
      int         exp_n;
      int         min_c;
      int         max_c;
   } vec_t;

   vec_t vecs [11];

   initial begin : main
      int xfer, cnt_r, off_r, cyc;
      logic [7:0] cmd_r;
      vecs[0]  = '{8'h10, 8'h02, 8'd6,  0,  1'b1, 1'b0, 8'd6,  0, 1,  20}; // no CU, terminator
      vecs[1]  = '{8'h10, 8'h02, 8'd6,  0,  1'b0, 1'b0, 8'd6,  0, 16, 20}; // no CU, timeout
      vecs[2]  = '{8'h1a, 8'h02, 8'd6,  16, 1'b1, 1'b0, 8'd6,  0, 1,  30}; // busy CU
      vecs[3]  = '{8'h20, 8'h02, 8'd6,  16, 1'b1, 1'b0, 8'd0,  6, 1,  85}; // read, stop
      vecs[4]  = '{8'h20, 8'h02, 8'd16, 6,  1'b1, 1'b0, 8'd10, 6, 1,  85}; // read, CU short
      vecs[5]  = '{8'h20, 8'h01, 8'd6,  16, 1'b1, 1'b0, 8'd0,  6, 1,  85}; // write, stop
      vecs[6]  = '{8'h20, 8'h01, 8'd16, 6,  1'b1, 1'b0, 8'd10, 6, 1,  85}; // write, CU short
      vecs[7]  = '{8'h20, 8'h03, 8'd0,  0,  1'b1, 1'b0, 8'd0,  0, 1,  30}; // NOP
      vecs[8]  = '{8'h20, 8'hff, 8'd4,  8,  1'b1, 1'b0, 8'd4,  0, 1,  30}; // invalid command
      vecs[9]  = '{8'h20, 8'h02, 8'd16, 6,  1'b1, 1'b1, 8'd10, 6, 1,  85}; // strobe mid-op ignored
      vecs[10] = '{8'h20, 8'h01, 8'd0,  3,  1'b1, 1'b0, 8'd0,  0, 1,  30}; // zero count, stop at once

      reset = 1'b1; start_strobe = 1'b0; address = 8'h00; command = 8'h00; count = 8'h00;
      cu_offer = 0; cu_term = 1'b1;
      repeat (3) @(negedge clk);
      check("reset operational_out", 32'(a_operational_out), 32'd0);
      check("reset state", 32'(dut.state), 32'(IDLE_CODE));
      check("reset res_count", 32'(dut.res_count), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset operational_out", 32'(a_operational_out), 32'd1);
      check("post_reset tags",
            32'({a_select_out, a_hold_out, a_address_out, a_command_out, a_service_out,
                 a_suppress_out, a_bus_out}), 32'd0);

      for (int v = 0; v < 11; v++)
         run_op(v, vecs[v].addr, vecs[v].cmd, vecs[v].cnt, vecs[v].offer, vecs[v].term,
                vecs[v].mid, vecs[v].exp_res, vecs[v].exp_n, vecs[v].min_c, vecs[v].max_c);

      for (int r = 0; r < 12; r++) begin
         cmd_r = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
         cnt_r = $urandom_range(0, 20);
         off_r = $urandom_range(0, 20);
         xfer  = model_xfer(CU_ADDR, cmd_r, cnt_r, off_r);
         run_op(100 + r, CU_ADDR, cmd_r, 8'(cnt_r), off_r, 1'b1, 1'b0,
                8'(cnt_r - xfer), xfer, 1, 40 + 8 * xfer);
      end

      // Reset in the middle of a read: everything drops on the next edge.
      for (int k = 0; k < 64; k++) rd_data[k] = 8'($urandom);
      wr_q.delete();
      cu_offer = 16; cu_term = 1'b1;
      address = CU_ADDR; command = 8'h02; count = 8'd16; start_strobe = 1'b1;
      @(negedge clk);
      start_strobe = 1'b0;
      repeat (10) @(negedge clk);
      check("midop select_active", 32'(a_select_out), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("midop_reset state", 32'(dut.state), 32'(IDLE_CODE));
      check("midop_reset res_count", 32'(dut.res_count), 32'd0);
      check("midop_reset tags",
            32'({a_select_out, a_hold_out, a_address_out, a_command_out, a_service_out, a_bus_out}), 32'd0);
      check("midop_reset operational_out", 32'(a_operational_out), 32'd0);
      reset = 1'b0;
      cyc = 0;
      while (a_operational_in !== 1'b0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("cu_released_after_reset", 32'(a_operational_in), 32'd0);
      repeat (2) @(negedge clk);
      check("midop_release operational_out", 32'(a_operational_out), 32'd1);
      run_op(200, CU_ADDR, 8'h01, 8'd5, 9, 1'b1, 1'b0, 8'd0, 5, 1, 85);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
